// File: rtl/data_sram_confreg_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_confreg_if
//  Description : Data SRAM port bundle between the CPU (master) and the
//                data-side memory responder (slave).
//                  we    - full-word write strobe
//                  addr  - byte address (bits [1:0] ignored by the slave)
//                  wdata - write data
//                  rdata - registered read data, one cycle after addr
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_sram_confreg_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/data_sram_confreg.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_confreg
//  Description : Data-side memory responder for the CPU data SRAM port.
//                Each access is decoded to either a word-addressed,
//                read-first RAM or a small configuration-register window
//                (LED, switches, numeric display, free-running timer,
//                simulation flag). Reads return one cycle after the address.
//  Ports       : clk       - sole clock, rising edge
//                reset     - synchronous, active-high reset
//                data_sram - slave side of the data SRAM bundle
//                switch    - asynchronous board switches (8 bits)
//                led       - LED register, active-low (16 bits)
//                num_data  - numeric-display register (32 bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_confreg #(
    parameter int          RAM_AW     = 14,
    parameter logic [31:0] CONF_BASE  = 32'hbfaf_0000,
    parameter bit          SIMULATION = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    data_sram_confreg_if.slave     data_sram,
    input  wire logic [7:0]        switch,
    output logic      [15:0]       led,
    output logic      [31:0]       num_data
);

    localparam logic [15:0] c_OFF_LED    = 16'h0000;
    localparam logic [15:0] c_OFF_SWITCH = 16'h0004;
    localparam logic [15:0] c_OFF_NUM    = 16'h0008;
    localparam logic [15:0] c_OFF_TIMER  = 16'h000c;
    localparam logic [15:0] c_OFF_SIMU   = 16'h0010;

    // ------------------------------------------------------------------
    // Address decode (every cycle, no enable)
    // ------------------------------------------------------------------
    logic              w_conf_hit;
    logic [15:0]       w_offset;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_conf_wr;
    logic              w_ram_wr;

    assign w_conf_hit = (data_sram.addr[31:16] == CONF_BASE[31:16]);
    assign w_offset   = data_sram.addr[15:0];
    // Upper address bits are dropped, so the RAM aliases across the space.
    assign w_ram_idx  = data_sram.addr[RAM_AW+1:2];
    assign w_conf_wr  = !reset && data_sram.we &&  w_conf_hit;
    assign w_ram_wr   = !reset && data_sram.we && !w_conf_hit;

    // ------------------------------------------------------------------
    // RAM: single port, read-first, contents never reset
    // ------------------------------------------------------------------
    logic [31:0] r_ram [0:(1<<RAM_AW)-1];
    logic [31:0] r_ram_rdata;

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= data_sram.wdata;
        end
        r_ram_rdata <= r_ram[w_ram_idx];
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [15:0] r_led;
    logic [31:0] r_num;
    logic [31:0] r_timer;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [31:0] w_simu_flag;

    generate
        if (SIMULATION) begin : g_simu_on
            assign w_simu_flag = 32'hffff_ffff;
        end else begin : g_simu_off
            assign w_simu_flag = 32'h0000_0000;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= 16'hffff;
            r_num     <= 32'h0;
            r_timer   <= 32'h0;
            r_sw_meta <= 8'h0;
            r_sw_sync <= 8'h0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;

            if (w_conf_wr && (w_offset == c_OFF_LED)) begin
                r_led <= data_sram.wdata[15:0];
            end
            if (w_conf_wr && (w_offset == c_OFF_NUM)) begin
                r_num <= data_sram.wdata;
            end
            // A load replaces the increment for that edge.
            if (w_conf_wr && (w_offset == c_OFF_TIMER)) begin
                r_timer <= data_sram.wdata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    assign led      = r_led;
    assign num_data = r_num;

    // Pre-edge register values, captured at the edge (read-first behaviour).
    logic [31:0] w_conf_rdata;

    always_comb begin
        w_conf_rdata = 32'h0;
        case (w_offset)
            c_OFF_LED:    w_conf_rdata = {16'h0, r_led};
            c_OFF_SWITCH: w_conf_rdata = {24'h0, r_sw_sync};
            c_OFF_NUM:    w_conf_rdata = r_num;
            c_OFF_TIMER:  w_conf_rdata = r_timer;
            c_OFF_SIMU:   w_conf_rdata = w_simu_flag;
            default:      w_conf_rdata = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    logic        r_rd_valid;   // low after a reset edge, forcing rdata to 0
    logic        r_rd_conf;
    logic [31:0] r_conf_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid   <= 1'b0;
            r_rd_conf    <= 1'b0;
            r_conf_rdata <= 32'h0;
        end else begin
            r_rd_valid   <= 1'b1;
            r_rd_conf    <= w_conf_hit;
            r_conf_rdata <= w_conf_rdata;
        end
    end

    assign data_sram.rdata = !r_rd_valid ? 32'h0 :
                             r_rd_conf   ? r_conf_rdata : r_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_confreg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_confreg
//  Description : Self-checking bench for data_sram_confreg: a vector table
//                for the directed cases, hand-written sequences for the
//                switch synchronizer and mid-operation reset, and random
//                traffic compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_confreg;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [31:0] num;

    always #5 clk = ~clk;

    data_sram_confreg_if bus();

    data_sram_confreg #(
        .RAM_AW     (14),
        .CONF_BASE  (32'hbfaf_0000),
        .SIMULATION (1'b1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .data_sram (bus),
        .switch    (sw),
        .led       (led),
        .num_data  (num)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: edge-indexed history plus plain storage
    // ------------------------------------------------------------------
    logic [31:0] ram_m [int];      // keyed by aliased word index
    logic [15:0] led_m;
    logic [31:0] num_m;
    logic [31:0] t_base;           // timer value loaded at edge t_edge
    int          t_edge;
    logic [7:0]  sw_eff [int];     // switch seen at each edge (0 in reset)
    bit          rst_hist [int];
    int          cyc = 0;          // index of the upcoming edge

    function automatic int ram_key(input logic [31:0] a);
        return int'((a >> 2) % 32'd16384);
    endfunction

    function automatic bit is_conf(input logic [31:0] a);
        return a[31:16] == 16'hbfaf;
    endfunction

    function automatic void model_read(input logic r, input logic [31:0] a,
                                       output logic [31:0] v, output bit known);
        known = 1'b1;
        v     = 32'h0;
        if (r) return;
        if (is_conf(a)) begin
            case (a[15:0])
                16'h0000: v = {16'h0, led_m};
                16'h0004: v = rst_hist[cyc-1] ? 32'h0 : {24'h0, sw_eff[cyc-2]};
                16'h0008: v = num_m;
                16'h000c: v = t_base + 32'(cyc - t_edge - 1);
                16'h0010: v = 32'hffff_ffff;
                default:  v = 32'h0;
            endcase
        end else if (ram_m.exists(ram_key(a))) begin
            v = ram_m[ram_key(a)];
        end else begin
            known = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // One access: drive, clock, update model, compare against the model.
    task automatic step(input logic r, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
        logic [31:0] exp;
        bit          known;
        reset     = r;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        model_read(r, addr, exp, known);
        @(posedge clk);
        rst_hist[cyc] = r;
        sw_eff[cyc]   = r ? 8'h0 : sw;
        if (r) begin
            led_m  = 16'hffff;
            num_m  = 32'h0;
            t_base = 32'h0;
            t_edge = cyc;
        end else if (we) begin
            if (is_conf(addr)) begin
                case (addr[15:0])
                    16'h0000: led_m = wdata[15:0];
                    16'h0008: num_m = wdata;
                    16'h000c: begin t_base = wdata; t_edge = cyc; end
                    default: ;
                endcase
            end else begin
                ram_m[ram_key(addr)] = wdata;
            end
        end
        cyc++;
        #1;
        got = bus.rdata;
        if (known) check("model_rdata", got, exp);
        check("model_led", {16'h0, led}, {16'h0, led_m});
        check("model_num", num, num_m);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (rdata is for this row's own address)
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
        logic [31:0] exp_num;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0] got;

        vecs[0]  = '{1'b1, 32'h1c00_0100, 32'hdead_beef, 1'b0, 32'h0,         16'hffff, 32'h0};
        vecs[1]  = '{1'b0, 32'h1c00_0100, 32'h0,         1'b1, 32'hdead_beef, 16'hffff, 32'h0};
        vecs[2]  = '{1'b0, 32'h1c01_0100, 32'h0,         1'b1, 32'hdead_beef, 16'hffff, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'h5,         1'b0, 32'h0,         16'hffff, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'h1,         1'b1, 32'h5,         16'hffff, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h1,         16'hffff, 32'h0};
        vecs[6]  = '{1'b1, 32'hbfaf_0000, 32'h0000_00a5, 1'b1, 32'h0000_ffff, 16'h00a5, 32'h0};
        vecs[7]  = '{1'b0, 32'hbfaf_0000, 32'h0,         1'b1, 32'h0000_00a5, 16'h00a5, 32'h0};
        vecs[8]  = '{1'b1, 32'hbfaf_0008, 32'h1234_5678, 1'b1, 32'h0,         16'h00a5, 32'h1234_5678};
        vecs[9]  = '{1'b0, 32'hbfaf_0008, 32'h0,         1'b1, 32'h1234_5678, 16'h00a5, 32'h1234_5678};
        vecs[10] = '{1'b1, 32'hbfaf_000c, 32'hffff_fffe, 1'b0, 32'h0,         16'h00a5, 32'h1234_5678};
        vecs[11] = '{1'b0, 32'hbfaf_000c, 32'h0,         1'b1, 32'hffff_fffe, 16'h00a5, 32'h1234_5678};
        vecs[12] = '{1'b0, 32'hbfaf_000c, 32'h0,         1'b1, 32'hffff_ffff, 16'h00a5, 32'h1234_5678};
        vecs[13] = '{1'b0, 32'hbfaf_000c, 32'h0,         1'b1, 32'h0000_0000, 16'h00a5, 32'h1234_5678};
        vecs[14] = '{1'b0, 32'hbfaf_0010, 32'h0,         1'b1, 32'hffff_ffff, 16'h00a5, 32'h1234_5678};
        vecs[15] = '{1'b0, 32'hbfaf_0020, 32'h0,         1'b1, 32'h0,         16'h00a5, 32'h1234_5678};
        vecs[16] = '{1'b1, 32'hbfaf_0004, 32'h55,        1'b1, 32'h0,         16'h00a5, 32'h1234_5678};
        vecs[17] = '{1'b1, 32'hbfaf_0014, 32'h99,        1'b1, 32'h0,         16'h00a5, 32'h1234_5678};

        sw = 8'h0;

        // Reset: rdata 0, led all-ones, num 0.
        step(1'b1, 1'b0, 32'h0, 32'h0, got);
        step(1'b1, 1'b0, 32'h0, 32'h0, got);
        check("reset_rdata", got, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0000_ffff);
        check("reset_num", num, 32'h0);

        for (int i = 0; i < 18; i++) begin
            step(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, got);
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rd);
            check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
            check($sformatf("vec%0d_num", i), num, vecs[i].exp_num);
        end

        // Switch synchronizer: present before edge t, visible from edge t+2 read.
        sw = 8'h3c;
        step(1'b0, 1'b0, 32'hbfaf_0004, 32'h0, got);
        check("sw_edge_t", got, 32'h0);
        step(1'b0, 1'b0, 32'hbfaf_0004, 32'h0, got);
        check("sw_edge_t1", got, 32'h0);
        step(1'b0, 1'b0, 32'hbfaf_0004, 32'h0, got);
        check("sw_edge_t2", got, 32'h0000_003c);
        step(1'b0, 1'b0, 32'hbfaf_0004, 32'h0, got);
        check("sw_edge_t3", got, 32'h0000_003c);

        // Mid-operation reset drops a concurrent RAM write.
        step(1'b0, 1'b1, 32'h0000_0080, 32'h11, got);
        step(1'b0, 1'b1, 32'hbfaf_0000, 32'h0, got);
        check("rst_led_zero", {16'h0, led}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 32'h0000_0080, 32'h7, got);
            check("rst_led", {16'h0, led}, 32'h0000_ffff);
            check("rst_rdata", got, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0000_0080, 32'h0, got);
        check("rst_ram_kept", got, 32'h11);
        step(1'b0, 1'b0, 32'hbfaf_000c, 32'h0, got);
        check("rst_timer", got, 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        we;
            logic [31:0] a;
            r  = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                a = {3'b000, 13'($urandom), 14'($urandom_range(0, 7) * 37 + 5), 2'($urandom)};
            end else begin
                a = {16'hbfaf, 16'($urandom_range(0, 9) * 4)};
            end
            step(r, we, a, $urandom, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
